// File: rtl/kanagawa_fifo_stream_reader_pkg.sv
// Shared types for the show-ahead FIFO stream reader: occupancy encoding and depth.
package kanagawa_fifo_reader_pkg;

   typedef enum logic [1:0] {RD_EMPTY, RD_ONE, RD_TWO} rd_occ_t;

   localparam int RD_MAX_OCC = 2;

endpackage

// File: rtl/kanagawa_fifo_stream_reader_if.sv
// FIFO read port plus valid/ready output stream; master = reader, slave = FIFO + consumer.
interface kanagawa_fifo_stream_reader_if #(
   parameter int WIDTH = 32
);
   logic             fifo_empty;
   logic [WIDTH-1:0] fifo_q;
   logic             fifo_rdreq;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (
      input  fifo_empty, fifo_q, out_ready,
      output fifo_rdreq, out_valid, out_data
   );

   modport slave (
      output fifo_empty, fifo_q, out_ready,
      input  fifo_rdreq, out_valid, out_data
   );
endinterface

// File: rtl/kanagawa_fifo_stream_reader_slots.sv
// Two-entry data store: slot0 is the presented head, slot1 the skid entry.
module kanagawa_fifo_stream_reader_slots #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             ld0_i,
   input  logic             ld1_i,
   input  logic             shift_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] slot0_o
);
   logic [WIDTH-1:0] slot0_q, slot0_d;
   logic [WIDTH-1:0] slot1_q, slot1_d;

   always_comb begin
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      if (ld0_i)
         slot0_d = din_i;
      else if (shift_i)
         slot0_d = slot1_q;
      if (ld1_i)
         slot1_d = din_i;
   end

   // Data carries no reset; occupancy in the parent decides what is meaningful.
   always_ff @(posedge clk_i) begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
   end

   assign slot0_o = slot0_q;
endmodule

// File: rtl/kanagawa_fifo_stream_reader.sv
// Show-ahead FIFO reader with a two-entry registered valid/ready output.
// Optional counters enabled by KANAGAWA_FIFO_READER_STATS_EN.
module kanagawa_fifo_stream_reader
   import kanagawa_fifo_reader_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int STAT_WIDTH = 32
) (
   input  logic                          clock,
   input  logic                          rst,
   input  logic                          flush,
   kanagawa_fifo_stream_reader_if.master bus
`ifdef KANAGAWA_FIFO_READER_STATS_EN
   ,
   output logic [STAT_WIDTH-1:0]         stat_beats,
   output logic [STAT_WIDTH-1:0]         stat_stalls
`endif
);
   rd_occ_t    cnt_q, cnt_d;
   logic       pop, acc;
   logic       ld0, ld1, shift;

   // rdreq looks only at registered occupancy, keeping out_ready off the FIFO path.
   assign bus.fifo_rdreq = ~rst & ~flush & ~bus.fifo_empty & (cnt_q != RD_TWO);
   assign pop            = bus.fifo_rdreq;
   assign acc            = bus.out_valid & bus.out_ready;
   assign bus.out_valid  = (cnt_q != RD_EMPTY);

   always_comb begin
      cnt_d = cnt_q;
      ld0   = 1'b0;
      ld1   = 1'b0;
      shift = 1'b0;
      case (cnt_q)
         RD_EMPTY: if (pop) begin
            cnt_d = RD_ONE;
            ld0   = 1'b1;
         end
         RD_ONE: begin
            if (pop && acc)
               ld0 = 1'b1;
            else if (pop) begin
               cnt_d = RD_TWO;
               ld1   = 1'b1;
            end else if (acc)
               cnt_d = RD_EMPTY;
         end
         RD_TWO: if (acc) begin
            cnt_d = RD_ONE;
            shift = 1'b1;
         end
         default: cnt_d = RD_EMPTY;
      endcase
      if (flush) begin
         cnt_d = RD_EMPTY;
         shift = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (rst) cnt_q <= RD_EMPTY;
      else     cnt_q <= cnt_d;
   end

   kanagawa_fifo_stream_reader_slots #(.WIDTH(WIDTH)) u_slots (
      .clk_i   (clock),
      .ld0_i   (ld0),
      .ld1_i   (ld1),
      .shift_i (shift),
      .din_i   (bus.fifo_q),
      .slot0_o (bus.out_data)
   );

`ifdef KANAGAWA_FIFO_READER_STATS_EN
   logic [STAT_WIDTH-1:0] beats_q, stalls_q;

   // Free-running counters; flush leaves them alone so delivered history survives.
   always_ff @(posedge clock) begin
      if (rst) begin
         beats_q  <= '0;
         stalls_q <= '0;
      end else begin
         if (acc)                            beats_q  <= beats_q + STAT_WIDTH'(1);
         if (bus.out_valid && !bus.out_ready) stalls_q <= stalls_q + STAT_WIDTH'(1);
      end
   end

   assign stat_beats  = beats_q;
   assign stat_stalls = stalls_q;
`endif

`ifndef NO_DYNAMIC_ASSERTS
   a_occ_max: assert property (@(posedge clock) disable iff (rst)
      int'(cnt_q) <= RD_MAX_OCC);
   a_stall_stable: assert property (@(posedge clock) disable iff (rst)
      (bus.out_valid && !bus.out_ready && !flush) |=> (bus.out_valid && $stable(bus.out_data)));
   a_no_underflow: assert property (@(posedge clock)
      bus.fifo_rdreq |-> !bus.fifo_empty);
`endif
endmodule
